mc_ctrl_v2: RTL

- Parametrised successor to the multi-cycle CPU controller FSM.
- Drives the shared-memory MIPS datapath: PC, IR, DR, A/B, ALUout, regfile, muxes.
- Adds immediate ALU ops, jal, jr and a memory ready handshake with timeout.
- Adds run/single-step advance control, so the core runs on the board clock instead of a button-derived clock.

---
 rtl/mc_ctrl_v2_if.sv | 44 ++++
 rtl/mc_ctrl_v2.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_v2_if.sv
// Control bus between the multi-cycle MIPS controller and its datapath.
// The controller takes the master side. The datapath (or a bench) takes the
// slave side: it drives the instruction fields, memory handshake and
// advance controls, and receives the decoded strobes and mux selects.
interface mc_ctrl_v2_if;
  logic       run;
  logic       step;
  logic [5:0] op;
  logic [5:0] funct;
  logic       mem_ready;

  logic [1:0] RegDst;
  logic       RegWrite;
  logic       ALUsrcA;
  logic [1:0] ALUsrcB;
  logic       ExtZero;
  logic [2:0] ALUop;
  logic       IorD;
  logic       IRwrite;
  logic       MemRead;
  logic       MemWrite;
  logic [1:0] MemToReg;
  logic       PCwrite;
  logic       PCWriteCond;
  logic       PCCondSrc;
  logic [1:0] PCsrc;
  logic [3:0] state;
  logic       halted;
  logic [1:0] err;

  modport master (
    input  run, step, op, funct, mem_ready,
    output RegDst, RegWrite, ALUsrcA, ALUsrcB, ExtZero, ALUop, IorD,
           IRwrite, MemRead, MemWrite, MemToReg, PCwrite, PCWriteCond,
           PCCondSrc, PCsrc, state, halted, err
  );

  modport slave (
    output run, step, op, funct, mem_ready,
    input  RegDst, RegWrite, ALUsrcA, ALUsrcB, ExtZero, ALUop, IorD,
           IRwrite, MemRead, MemWrite, MemToReg, PCwrite, PCWriteCond,
           PCCondSrc, PCsrc, state, halted, err
  );
endinterface

// File: rtl/mc_ctrl_v2.sv
// Multi-cycle MIPS controller FSM for the shared-memory datapath.
// Supports R-type, lw/sw, beq/bne, j, optional immediate ALU ops and
// jal/jr, a memory ready handshake with a timeout, and run / single-step
// advance so the core can be clocked from the board oscillator.
// Mux selects are held in a registered control word chosen on entry to each
// state; write strobes are that word gated by the advance qualifier so that
// nothing is written on cycles where the FSM stands still.
module mc_ctrl_v2 #(
  parameter int MEM_TIMEOUT = 16,
  parameter bit HAS_IMM     = 1'b1,
  parameter bit HAS_JAL     = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  mc_ctrl_v2_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11,
    S_JAL    = 4'd12,
    S_JR     = 4'd13,
    S_HALT   = 4'd15
  } state_t;

  typedef struct packed {
    logic [1:0] RegDst;
    logic       RegWrite;
    logic       ALUsrcA;
    logic [1:0] ALUsrcB;
    logic       ExtZero;
    logic [2:0] ALUop;
    logic       IorD;
    logic       IRwrite;
    logic       MemRead;
    logic       MemWrite;
    logic [1:0] MemToReg;
    logic       PCwrite;
    logic       PCWriteCond;
    logic       PCCondSrc;
    logic [1:0] PCsrc;
    logic       halted;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] F_JR     = 6'b001000;

  // The wait counter only ever needs to hold MEM_TIMEOUT-1; the halt fires on
  // the advance that would make it reach MEM_TIMEOUT.
  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = (MEM_TIMEOUT > 0) ? CW'(MEM_TIMEOUT - 1) : '0;

  state_t        state_q, state_d;
  ctrl_t         ctrl_q;
  logic [1:0]    err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          step_q;
  logic          adv;
  logic          waitState;
  logic          illegal;

  // Control word for a state. The only op-dependent entries are the branch
  // condition select and the immediate ALU function; both are taken while op
  // (the IR) is stable.
  function automatic ctrl_t ctrlFor(input state_t s, input logic [5:0] opc);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.MemRead = 1'b1;
        c.ALUsrcB = 2'b01;
        c.IRwrite = 1'b1;
        c.PCwrite = 1'b1;
      end
      S_DECODE: c.ALUsrcB = 2'b11;
      S_MEMADR: begin
        c.ALUsrcA = 1'b1;
        c.ALUsrcB = 2'b10;
      end
      S_MEMRD: begin
        c.MemRead = 1'b1;
        c.IorD    = 1'b1;
      end
      S_MEMWB: begin
        c.MemToReg = 2'b01;
        c.RegWrite = 1'b1;
      end
      S_MEMWR: begin
        c.MemWrite = 1'b1;
        c.IorD     = 1'b1;
      end
      S_EXEC: begin
        c.ALUsrcA = 1'b1;
        c.ALUop   = 3'b010;
      end
      S_RWB: begin
        c.RegDst   = 2'b01;
        c.RegWrite = 1'b1;
      end
      S_BRANCH: begin
        c.ALUsrcA     = 1'b1;
        c.ALUop       = 3'b001;
        c.PCWriteCond = 1'b1;
        c.PCsrc       = 2'b01;
        c.PCCondSrc   = (opc == OP_BEQ);
      end
      S_JUMP: begin
        c.PCwrite = 1'b1;
        c.PCsrc   = 2'b10;
      end
      S_IEXEC, S_IWB: begin
        c.ALUsrcA  = 1'b1;
        c.ALUsrcB  = 2'b10;
        c.RegWrite = (s == S_IWB);
        case (opc)
          OP_SLTI: c.ALUop = 3'b101;
          OP_ANDI: begin
            c.ALUop   = 3'b011;
            c.ExtZero = 1'b1;
          end
          OP_ORI: begin
            c.ALUop   = 3'b100;
            c.ExtZero = 1'b1;
          end
          default: c.ALUop = 3'b000;
        endcase
      end
      S_JAL: begin
        c.RegDst   = 2'b10;
        c.MemToReg = 2'b10;
        c.RegWrite = 1'b1;
        c.PCwrite  = 1'b1;
        c.PCsrc    = 2'b10;
      end
      S_JR: begin
        c.ALUsrcA = 1'b1;
        c.PCwrite = 1'b1;
        c.PCsrc   = 2'b11;
      end
      S_HALT: c.halted = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  // One advance per cycle in run mode, or one per rising edge of step;
  // nothing advances while reset is held.
  assign adv       = rst & (bus.run | (bus.step & ~step_q));
  assign waitState = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);

  // Next state, error code and memory wait counter.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    illegal = 1'b0;
    if (waitState && bus.mem_ready) cnt_d = '0;
    if (adv) begin
      case (state_q)
        S_FETCH, S_MEMRD, S_MEMWR: begin
          if (bus.mem_ready) begin
            if (state_q == S_FETCH)      state_d = S_DECODE;
            else if (state_q == S_MEMRD) state_d = S_MEMWB;
            else                         state_d = S_FETCH;
          end else if ((MEM_TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
            state_d = S_HALT;
            err_d   = 2'b10;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_DECODE: begin
          case (bus.op)
            OP_RTYPE: begin
              if (bus.funct == F_JR) begin
                if (HAS_JAL) state_d = S_JR;
                else         illegal = 1'b1;
              end else begin
                state_d = S_EXEC;
              end
            end
            OP_LW, OP_SW:   state_d = S_MEMADR;
            OP_BEQ, OP_BNE: state_d = S_BRANCH;
            OP_J:           state_d = S_JUMP;
            OP_JAL: begin
              if (HAS_JAL) state_d = S_JAL;
              else         illegal = 1'b1;
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
              if (HAS_IMM) state_d = S_IEXEC;
              else         illegal = 1'b1;
            end
            default: illegal = 1'b1;
          endcase
          if (illegal) begin
            state_d = S_HALT;
            err_d   = 2'b01;
          end
        end
        S_MEMADR: state_d = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
        S_EXEC:   state_d = S_RWB;
        S_IEXEC:  state_d = S_IWB;
        S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_IWB, S_JAL, S_JR: state_d = S_FETCH;
        S_HALT:   state_d = S_HALT;
        default:  state_d = S_HALT;
      endcase
    end
    if (state_d != state_q) cnt_d = '0;
  end

  // State, control word, error, wait counter and step edge register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
      ctrl_q  <= ctrlFor(S_FETCH, 6'b000000);
      err_q   <= 2'b00;
      cnt_q   <= '0;
      step_q  <= 1'b0;
    end else begin
      step_q  <= bus.step;
      state_q <= state_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      if (adv) ctrl_q <= ctrlFor(state_d, bus.op);
    end
  end

  // FETCH carries both IRwrite and PCwrite but may only commit them once
  // memory has delivered the instruction; the jump-style PC loads are
  // unconditional.
  assign bus.IRwrite     = adv & ctrl_q.IRwrite & bus.mem_ready;
  assign bus.PCwrite     = adv & ctrl_q.PCwrite & (~ctrl_q.IRwrite | bus.mem_ready);
  assign bus.RegWrite    = adv & ctrl_q.RegWrite;
  assign bus.MemWrite    = adv & ctrl_q.MemWrite;
  assign bus.PCWriteCond = adv & ctrl_q.PCWriteCond;

  assign bus.RegDst      = ctrl_q.RegDst;
  assign bus.ALUsrcA     = ctrl_q.ALUsrcA;
  assign bus.ALUsrcB     = ctrl_q.ALUsrcB;
  assign bus.ExtZero     = ctrl_q.ExtZero;
  assign bus.ALUop       = ctrl_q.ALUop;
  assign bus.IorD        = ctrl_q.IorD;
  assign bus.MemRead     = ctrl_q.MemRead;
  assign bus.MemToReg    = ctrl_q.MemToReg;
  assign bus.PCCondSrc   = ctrl_q.PCCondSrc;
  assign bus.PCsrc       = ctrl_q.PCsrc;
  assign bus.halted      = ctrl_q.halted;
  assign bus.state       = state_q;
  assign bus.err         = err_q;

endmodule
